// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: prioritised stage enables,
// saturating event counters and a data-memory stall watchdog with sticky error.
module pipeline_stall_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 1024,
    parameter int TO_WIDTH  = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bubble_i,
    input  logic                 flush_i,
    input  logic                 mem_stall_i,
    output logic                 PC_write_o,
    output logic                 IF_ID_write_o,
    output logic                 IF_ID_flush_o,
    output logic                 ID_EX_write_o,
    output logic                 ID_EX_bubble_o,
    output logic                 EX_MEM_write_o,
    output logic                 MEM_WB_bubble_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic                 error_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HANG     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TO_WIDTH-1:0]   wdog_q, wdog_d;
    logic                  error_q, error_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        if (inc && (v != {CNT_WIDTH{1'b1}}))
            return v + CNT_WIDTH'(1);
        return v;
    endfunction

    // One priority level per cycle; a frozen pipeline holds bubble/flush requests
    // so they are simply re-evaluated once the memory stall releases.
    always_comb begin
        PC_write_o      = 1'b1;
        IF_ID_write_o   = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_write_o   = 1'b1;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_write_o  = 1'b1;
        MEM_WB_bubble_o = 1'b0;
        if (mem_stall_i) begin
            PC_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            ID_EX_write_o   = 1'b0;
            EX_MEM_write_o  = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (bubble_i) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
        end else if (flush_i) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, mem_stall_i);
        bubble_cnt_d = sat_inc(bubble_cnt_q, ID_EX_bubble_o);
        flush_cnt_d  = sat_inc(flush_cnt_q, IF_ID_flush_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            wdog_q       <= '0;
            error_q      <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            error_q      <= error_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Watchdog counts consecutive stalled cycles; the cycle that reaches
    // TIMEOUT moves to HANG and latches the error until reset.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        error_d = error_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_i) begin
                    state_d = ST_MEM_WAIT;
                    wdog_d  = TO_WIDTH'(1);
                end else begin
                    wdog_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall_i) begin
                    state_d = ST_RUN;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + TO_WIDTH'(1);
                    if (wdog_d == TO_WIDTH'(TIMEOUT)) begin
                        state_d = ST_HANG;
                        error_d = 1'b1;
                    end
                end
            end
            ST_HANG: begin
                if (!mem_stall_i) begin
                    state_d = ST_RUN;
                    wdog_d  = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                wdog_d  = '0;
            end
        endcase
    end

    always_comb begin
        state_o      = state_q;
        error_o      = error_q;
        stall_cnt_o  = stall_cnt_q;
        bubble_cnt_o = bubble_cnt_q;
        flush_cnt_o  = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: control truth table, directed corner sequences
// and random traffic against an event-count/run-length reference model.
module tb_pipeline_stall_ctrl;

    localparam int CW  = 4;
    localparam int TO  = 4;
    localparam int TOW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_i = 1'b1, bubble_i = 1'b0, flush_i = 1'b0, mem_stall_i = 1'b0;
    logic PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o;
    logic ID_EX_bubble_o, EX_MEM_write_o, MEM_WB_bubble_o, error_o;
    logic [CW-1:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: event totals, length of the current stall run, sticky error.
    int m_stall, m_bub, m_fl, m_run, m_state;
    bit m_err;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_WIDTH(CW), .TIMEOUT(TO), .TO_WIDTH(TOW)) dut (
        .clk_i(clk), .rst_i(rst_i), .bubble_i(bubble_i), .flush_i(flush_i),
        .mem_stall_i(mem_stall_i), .PC_write_o(PC_write_o),
        .IF_ID_write_o(IF_ID_write_o), .IF_ID_flush_o(IF_ID_flush_o),
        .ID_EX_write_o(ID_EX_write_o), .ID_EX_bubble_o(ID_EX_bubble_o),
        .EX_MEM_write_o(EX_MEM_write_o), .MEM_WB_bubble_o(MEM_WB_bubble_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
        .flush_cnt_o(flush_cnt_o), .error_o(error_o), .state_o(state_o)
    );

    typedef struct {
        logic       b;
        logic       f;
        logic       s;
        logic [6:0] ctrl; // {PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_bub, EXMEM_w, MEMWB_bub}
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_ctrl(input logic b, input logic f, input logic s);
        if (s) return 7'b0000001;
        if (b) return 7'b0001110;
        if (f) return 7'b1111010;
        return 7'b1101010;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_edge(input logic b, input logic f, input logic s, input logic r);
        if (r) begin
            m_stall = 0; m_bub = 0; m_fl = 0; m_run = 0; m_err = 0; m_state = 0;
        end else if (s) begin
            m_stall = sat(m_stall);
            m_run++;
            if (m_run >= TO) m_err = 1;
            m_state = (m_run >= TO) ? 2 : 1;
        end else begin
            m_run = 0;
            m_state = 0;
            if (b) m_bub = sat(m_bub);
            else if (f) m_fl = sat(m_fl);
        end
    endtask

    // Drive one cycle: controls checked in-cycle, registered state after the edge.
    task automatic cyc(input logic b, input logic f, input logic s, input logic r,
                       input logic [6:0] exp_ctrl);
        logic [6:0] act;
        bubble_i = b; flush_i = f; mem_stall_i = s; rst_i = r;
        #1;
        act = {PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o,
               ID_EX_bubble_o, EX_MEM_write_o, MEM_WB_bubble_o};
        chk("ctrl", int'(act), int'(exp_ctrl));
        @(posedge clk);
        #1;
        model_edge(b, f, s, r);
        chk("stall_cnt", int'(stall_cnt_o), m_stall);
        chk("bubble_cnt", int'(bubble_cnt_o), m_bub);
        chk("flush_cnt", int'(flush_cnt_o), m_fl);
        chk("state", int'(state_o), m_state);
        chk("error", int'(error_o), int'(m_err));
        $display("t=%0t rst=%b b=%b f=%b s=%b ctrl=%b cnt=%0d/%0d/%0d st=%0d err=%b",
                 $time, r, b, f, s, act, stall_cnt_o, bubble_cnt_o, flush_cnt_o,
                 state_o, error_o);
    endtask

    task automatic step(input logic b, input logic f, input logic s, input logic r);
        cyc(b, f, s, r, ref_ctrl(b, f, s));
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 7'b1101010};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 7'b1111010};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 7'b0001110};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 7'b0001110};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 7'b0000001};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 7'b0000001};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 7'b0000001};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 7'b0000001};

        // Reset, then idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("idle_state", int'(state_o), 0);
        chk("idle_stall_cnt", int'(stall_cnt_o), 0);

        for (int i = 0; i < 8; i++) cyc(vecs[i].b, vecs[i].f, vecs[i].s, 1'b0, vecs[i].ctrl);

        // Single bubble
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("bubble_once", int'(bubble_cnt_o), 1);
        // Bubble plus flush: flush suppressed
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        chk("bub_flush_bcnt", int'(bubble_cnt_o), 1);
        chk("bub_flush_fcnt", int'(flush_cnt_o), 0);

        // Three-cycle stall with flush held
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0);
            chk("stall3_state", int'(state_o), 1);
        end
        chk("stall3_cnt", int'(stall_cnt_o), 3);
        chk("stall3_fcnt", int'(flush_cnt_o), 0);
        step(0, 0, 0, 0);
        chk("stall3_release", int'(state_o), 0);

        // TIMEOUT-1 cycles: no error; TIMEOUT cycles: error and HANG
        step(0, 0, 0, 1);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 1, 0);
        chk("to_minus1_err", int'(error_o), 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < TO; i++) step(0, 0, 1, 0);
        chk("to_err", int'(error_o), 1);
        chk("to_hang", int'(state_o), 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("hang_release_state", int'(state_o), 0);
        chk("hang_release_err", int'(error_o), 1);
        step(0, 0, 0, 0);
        chk("err_sticky", int'(error_o), 1);

        // Flush saturation, then reset mid-stall
        step(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("flush_sat", int'(flush_cnt_o), 15);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_stall_cnt", int'(stall_cnt_o), 0);
        chk("rst_mid_flush_cnt", int'(flush_cnt_o), 0);

        // Random traffic with bursts of memory stalls
        for (int i = 0; i < 400; i++) begin
            logic rb, rf, rs, rr;
            rb = ($urandom_range(0, 3) == 0);
            rf = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 9) < 5);
            rr = ($urandom_range(0, 99) == 0);
            step(rb, rf, rs, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Consumes the load-use bubble request from hazard detection, the ID-stage branch/jump flush request and the data-memory stall, and drives the write-enable/flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Also keeps saturating performance counters and a data-memory stall watchdog with a sticky error flag.

## Interface
- CNT_WIDTH, 32, width of each performance counter
- TIMEOUT, 1024, consecutive mem-stall cycles after which error_o sets (≥2)
- TO_WIDTH, 11, width of watchdog counter (must hold TIMEOUT)

- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- bubble_i  input  1  load-use hazard request from hazard detection
- flush_i  input  1  branch taken / jump resolved in ID
- mem_stall_i  input  1  data memory not ready this cycle
- PC_write_o  output  1  PC register enable
- IF_ID_write_o  output  1  IF/ID register enable
- IF_ID_flush_o  output  1  zero IF/ID on next edge
- ID_EX_write_o  output  1  ID/EX register enable
- ID_EX_bubble_o  output  1  zero ID/EX control fields on next edge
- EX_MEM_write_o  output  1  EX/MEM register enable
- MEM_WB_bubble_o  output  1  zero MEM/WB control fields on next edge
- stall_cnt_o  output  CNT_WIDTH  cycles with mem_stall_i high
- bubble_cnt_o  output  CNT_WIDTH  load-use bubbles inserted
- flush_cnt_o  output  CNT_WIDTH  IF/ID flushes performed
- error_o  output  1  sticky watchdog timeout
- state_o  output  2  FSM state (RUN=0, MEM_WAIT=1, HANG=2)

## Operation
- Control outputs are combinational from inputs; one priority level applies per cycle: mem_stall_i > bubble_i > flush_i > none.
- mem_stall_i=1: PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0, MEM_WB_bubble=1, IF_ID_flush=0, ID_EX_bubble=0. bubble_i/flush_i ignored (held by frozen pipeline, re-evaluated after release).
- bubble_i=1 (no mem stall): PC_write=0, IF_ID_write=0, ID_EX_bubble=1, ID_EX_write=1, EX_MEM_write=1. flush_i suppressed (branch operands not yet valid).
- flush_i=1 alone: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_write=1, EX_MEM_write=1.
- None: all *_write=1, all flush/bubble=0.
- Counters: stall_cnt +1 each cycle mem_stall_i=1; bubble_cnt +1 each cycle bubble output asserted via bubble_i; flush_cnt +1 each cycle IF_ID_flush_o=1. All saturate at 2^CNT_WIDTH−1 (no wrap).
- FSM:
  - RUN: mem_stall_i=1 → MEM_WAIT, watchdog ← 1; else stay, watchdog ← 0.
  - MEM_WAIT: mem_stall_i=0 → RUN, watchdog ← 0; mem_stall_i=1 → watchdog+1; if watchdog+1 == TIMEOUT → HANG, error_o ← 1.
  - HANG: error_o stays 1; mem_stall_i=0 → RUN (error_o stays set). Control outputs behave identically in all states.
- error_o cleared only by rst_i.

## Timing
- Control outputs: zero latency, same cycle as inputs.
- Counters, watchdog, state, error_o: update on the rising edge after the qualifying cycle.
- Reset (rst_i=1 at edge): state=RUN, watchdog=0, all counters=0, error_o=0. Controls during reset cycle remain combinational from inputs; reset mid-stall returns to RUN with counters cleared next cycle regardless of mem_stall_i.
- Stall of exactly TIMEOUT consecutive cycles sets error_o at edge closing cycle TIMEOUT; TIMEOUT−1 cycles does not.
- Simultaneous mem_stall_i+bubble_i+flush_i: only stall_cnt increments.

## Test plan
- Reset then idle 5 cycles -> all *_write=1, flush/bubble=0, counters 0, state_o=0, error_o=0.
- bubble_i=1 one cycle -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 same cycle; bubble_cnt_o=1 next cycle.
- bubble_i=1 and flush_i=1 together -> IF_ID_flush=0, ID_EX_bubble=1; flush_cnt_o stays 0, bubble_cnt_o=1.
- mem_stall_i=1 for 3 cycles with flush_i=1 -> all writes 0, MEM_WB_bubble=1, state_o=1; after release stall_cnt_o=3, flush_cnt_o=0, state_o=0.
- TIMEOUT=4: mem_stall_i high 3 cycles -> error_o=0; high 4 cycles -> error_o=1, state_o=2; release -> state_o=0, error_o=1 until rst_i.
- CNT_WIDTH=4: 20 flush cycles -> flush_cnt_o saturates at 15; rst_i mid-stall -> counters 0, state_o=0 next cycle.
